// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg: shared UART constants, FSM state encoding and baud helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic int clks_per_bit(input int sys_clk_freq, input int baud_rate);
    return sys_clk_freq / baud_rate;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_byte_fifo.sv
// ============================================================================
// uart_byte_fifo: synchronous first-word fall-through FIFO with registered
// full/empty/count flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = DATA_BITS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en_i,
  input  logic [WIDTH-1:0]             wr_data_i,
  input  logic                         rd_en_i,
  output logic [WIDTH-1:0]             rd_data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             w_push, w_pop;

  // A push is judged against the pre-edge full flag, even if a pop frees a slot.
  assign w_push = wr_en_i && !full_q;
  assign w_pop  = rd_en_i && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign count_o   = count_q;

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// uart_tx_fifo: buffered UART transmitter, back-to-back 8N1 frames from a FIFO.
// Optional macro UART_TX_PARITY_EN adds an even parity bit (8E1).
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_RATE    = 9600,
  parameter int SYS_CLK_FREQ = 12000000,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [DATA_BITS-1:0]              wr_data,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow,
  output logic                              tx,
  output logic                              is_transmitting
);

  localparam int CLKS = clks_per_bit(SYS_CLK_FREQ, BAUD_RATE);
  localparam int CW   = (CLKS > 1) ? $clog2(CLKS) : 1;
  localparam int BW   = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 overflow_q, overflow_d;
  logic                 w_baud_last, w_pop, w_empty, w_full;
  logic [DATA_BITS-1:0] w_head;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_data),
    .rd_en_i   (w_pop),
    .rd_data_o (w_head),
    .full_o    (w_full),
    .empty_o   (w_empty),
    .count_o   (fifo_count)
  );

  assign w_baud_last = (baud_q == BAUD_LAST);
  // Popping at the last STOP cycle chains frames with zero idle time.
  assign w_pop = !w_empty && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && w_baud_last));
  assign overflow_d = overflow_q | (wr_en & w_full);

  always_comb begin
    state_d   = state_q;
    baud_d    = w_baud_last ? '0 : baud_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
    if (w_pop) parity_d = ^w_head;
`endif
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (w_pop) begin
          state_d = ST_START;
          shift_d = w_head;
        end
      end
      ST_START: begin
        if (w_baud_last) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (w_baud_last) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_baud_last) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (w_baud_last) begin
          if (w_pop) begin
            state_d = ST_START;
            shift_d = w_head;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
      end
    endcase
  end

  // tx follows the next state so the pin toggles on the same edge as the FSM.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx              = tx_q;
  assign is_transmitting = (state_q != ST_IDLE);
  assign overflow        = overflow_q;
  assign full            = w_full;
  assign empty           = w_empty;

endmodule

`default_nettype wire
